mux: RTL and testbench
======================

// Module: mux
//
// PURPOSE
// - Registered N:1 single-bit multiplexer: selects one bit of a 2**SEL_WIDTH-bit input bus
//   by a binary select and presents it on a registered output one clock later.
// - Generic datapath leaf for control/steering logic. Output is glitch-free (flop-driven).
//
// PARAMETERS
// - SEL_WIDTH  default 2  width of select; input bus width = 2**SEL_WIDTH (legal range 1..8)
//
// PORTS
// - CLK      in   1                 single clock; all state updates on rising edge
// - RST      in   1                 reset, synchronous, active-low
// - mux_IN   in   2**SEL_WIDTH      data bits; bit i is candidate i
// - mux_SEL  in   SEL_WIDTH         binary index of selected bit (0 = LSB)
// - mux_OUT  out  1                 registered selected bit
//
// BEHAVIOUR
// - Reset: one clock domain (CLK); reset is synchronous, active-low (RST). On a rising CLK
//   edge with RST=0: mux_OUT <= 0. Asynchronous RST transitions have no effect until the next edge.
// - Normal: on each rising CLK edge with RST=1: mux_OUT <= mux_IN[mux_SEL].
// - Latency: exactly 1 cycle. Inputs stable before rising edge k -> mux_OUT valid after
//   edge k, held until edge k+1. No input registering; no extra pipeline stages.
// - No handshake: new select/data accepted every cycle; back-to-back changes each
//   produce a result one edge later.
// - Select range: all 2**SEL_WIDTH codes valid; no out-of-range case exists.
// - X/Z on mux_SEL: output value unspecified; no assertion required in RTL.
// - Reset mid-operation: reset wins over data on the same edge; first post-reset edge
//   with RST=1 loads mux_IN[mux_SEL] normally (no warm-up cycles).
// - Simultaneous change of mux_IN and mux_SEL in one cycle: output reflects the new pair.
// - Combinational path: mux_IN/mux_SEL -> D input of output flop only; no comb path to mux_OUT.
//
// STRUCTURE
// - Selection implemented as a balanced binary tree of SEL_WIDTH levels of 2:1 cells,
//   level L steered by mux_SEL[L] (level 0 = LSB pairs adjacent input bits), built with
//   generate loops; tree root feeds a single output flop in this module.
// - Sub-module: mux2 (1-bit 2:1 cell: a, b, s -> y = s ? b : a), instantiated per node.
// - Shared package: none required; SEL_WIDTH is a per-instance parameter. A width
//   helper (localparam N_IN = 1 << SEL_WIDTH) is local to the module.
//
// TESTING (SEL_WIDTH=2, CLK period 10 ns, drive on falling edge, check at next falling edge)
// - Reset: RST=0 for one edge with mux_IN=4'b1111, SEL=0 -> mux_OUT=0; release RST=1.
// - SEL=0: IN=4'b1010 -> OUT=0; IN=4'b1111 -> OUT=1 (one cycle each).
// - SEL=1: IN=4'b0110 -> OUT=1; IN=4'b0101 -> OUT=0.
// - SEL=2/3: IN=4'b1010,S=2 -> 0; 4'b1110,S=2 -> 1; 4'b0110,S=3 -> 0; 4'b1101,S=3 -> 1.
// - Latency: change IN right after a rising edge; mux_OUT must not change until the
//   next rising edge (no combinational feed-through).
// - Reset mid-stream: with OUT=1 (IN=4'b1101,S=3), assert RST=0 one edge -> OUT=0;
//   release -> OUT=1 after the next edge. Repeat all codes with SEL_WIDTH=3 exhaustively.

Source files
------------

// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//   Shared constants and elaboration helpers for the registered N:1 bit mux.
//   The select tree is stored as a heap: node 1 is the root, node k has
//   children 2k and 2k+1, and the leaves (input bits) occupy N_IN..2*N_IN-1.
//   No ports; imported by mux.
// ----------------------------------------------------------------------------
package mux_pkg;

    // Legal select width range for the tree builder.
    localparam int SEL_WIDTH_MIN = 1;
    localparam int SEL_WIDTH_MAX = 8;

    // A node at heap depth `depth` (root = 0) steers with this select bit.
    // The deepest internal level pairs adjacent inputs and therefore uses
    // select bit 0; the root uses the MSB.
    function automatic int sel_bit_for_depth(input int depth, input int sel_width);
        return sel_width - 1 - depth;
    endfunction

endpackage

// File: rtl/mux_mux2.sv
// ----------------------------------------------------------------------------
// mux2
//   1-bit 2:1 selection cell, one per node of the select tree.
//   Ports:
//     a  in  1   candidate chosen when s = 0
//     b  in  1   candidate chosen when s = 1
//     s  in  1   select
//     y  out 1   selected bit (combinational)
// ----------------------------------------------------------------------------
module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux.sv
// ----------------------------------------------------------------------------
// mux
//   Registered N:1 single-bit multiplexer. Selects mux_IN[mux_SEL] through a
//   balanced tree of 2:1 cells and registers it; mux_OUT is flop-driven, one
//   cycle after the inputs are sampled.
//   Parameters:
//     SEL_WIDTH  select width, input bus is 2**SEL_WIDTH bits (1..8)
//   Ports:
//     CLK      in   1             clock, rising edge
//     RST      in   1             synchronous reset, active low
//     mux_IN   in   2**SEL_WIDTH  candidate bits, bit i is candidate i
//     mux_SEL  in   SEL_WIDTH     binary index of the selected bit
//     mux_OUT  out  1             registered selected bit (0 in reset)
// ----------------------------------------------------------------------------
module mux
    import mux_pkg::*;
#(
    parameter int SEL_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [(1<<SEL_WIDTH)-1:0] mux_IN,
    input  logic [SEL_WIDTH-1:0]      mux_SEL,
    output logic                      mux_OUT
);

    localparam int N_IN = 1 << SEL_WIDTH;

    // Heap-ordered tree: [N_IN +: N_IN] are leaves, tree[1] is the root.
    logic [2*N_IN-1:1] tree;

    assign tree[2*N_IN-1:N_IN] = mux_IN;

    genvar d, j;
    generate
        for (d = 0; d < SEL_WIDTH; d++) begin : g_lvl
            localparam int SB = sel_bit_for_depth(d, SEL_WIDTH);
            for (j = 0; j < (1 << d); j++) begin : g_node
                localparam int K = (1 << d) + j;
                mux2 u_cell (
                    .a (tree[2*K]),
                    .b (tree[2*K+1]),
                    .s (mux_SEL[SB]),
                    .y (tree[K])
                );
            end
        end
    endgenerate

    // Single output flop; reset takes priority over the selected data.
    always_ff @(posedge CLK) begin
        if (!RST) mux_OUT <= 1'b0;
        else      mux_OUT <= tree[1];
    end

endmodule

// File: tb/tb_mux.sv
// ----------------------------------------------------------------------------
// tb_mux
//   Directed bench for mux at SEL_WIDTH=2 and SEL_WIDTH=3. Inputs change on
//   the falling edge; outputs are sampled on the following falling edge.
// ----------------------------------------------------------------------------
module tb_mux;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] in2;
    logic [1:0] sel2;
    logic       out2;
    logic [7:0] in3;
    logic [2:0] sel3;
    logic       out3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mux #(.SEL_WIDTH(2)) dut2 (
        .CLK     (CLK),
        .RST     (RST),
        .mux_IN  (in2),
        .mux_SEL (sel2),
        .mux_OUT (out2)
    );

    mux #(.SEL_WIDTH(3)) dut3 (
        .CLK     (CLK),
        .RST     (RST),
        .mux_IN  (in3),
        .mux_SEL (sel3),
        .mux_OUT (out3)
    );

    // Drive the 4-input DUT and advance to the next falling edge.
    task automatic step2(input logic [3:0] i, input logic [1:0] s);
        in2  = i;
        sel2 = s;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST  = 1'b0;
        in3  = 8'hFF;
        sel3 = 3'd0;
        step2(4'b1111, 2'd0);
        n_cmp++;
        if (out2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_w2: got %b want 0", out2);
        end
        n_cmp++;
        if (out3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_w3: got %b want 0", out3);
        end
        RST = 1'b1;
    endtask

    task automatic test_sel0;
        step2(4'b1010, 2'd0);
        n_cmp++;
        if (out2 !== 1'b0) begin
            n_bad++;
            $display("FAIL sel0_a: got %b want 0", out2);
        end
        step2(4'b1111, 2'd0);
        n_cmp++;
        if (out2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sel0_b: got %b want 1", out2);
        end
    endtask

    task automatic test_sel1;
        step2(4'b0110, 2'd1);
        n_cmp++;
        if (out2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sel1_a: got %b want 1", out2);
        end
        step2(4'b0101, 2'd1);
        n_cmp++;
        if (out2 !== 1'b0) begin
            n_bad++;
            $display("FAIL sel1_b: got %b want 0", out2);
        end
    endtask

    task automatic test_sel23;
        logic [3:0] vi [4] = '{4'b1010, 4'b1110, 4'b0110, 4'b1101};
        logic [1:0] vs [4] = '{2'd2,    2'd2,    2'd3,    2'd3};
        logic       ve [4] = '{1'b0,    1'b1,    1'b0,    1'b1};
        for (int k = 0; k < 4; k++) begin
            step2(vi[k], vs[k]);
            n_cmp++;
            if (out2 !== ve[k]) begin
                n_bad++;
                $display("FAIL sel23_%0d: in=%b sel=%0d got %b want %b",
                         k, vi[k], vs[k], out2, ve[k]);
            end
        end
    endtask

    // Output must only move on a rising edge, never straight from the inputs.
    task automatic test_latency;
        step2(4'b1111, 2'd0);
        @(posedge CLK);
        #1;
        in2 = 4'b0000;
        #2;
        n_cmp++;
        if (out2 !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_hold_early: got %b want 1", out2);
        end
        @(negedge CLK);
        n_cmp++;
        if (out2 !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_hold_late: got %b want 1", out2);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (out2 !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_update: got %b want 0", out2);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        logic [3:0] vi [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0101};
        logic [1:0] vs [4] = '{2'd0,    2'd1,    2'd3,    2'd3};
        logic       ve [4] = '{1'b0,    1'b1,    1'b1,    1'b0};
        for (int k = 0; k < 4; k++) begin
            step2(vi[k], vs[k]);
            n_cmp++;
            if (out2 !== ve[k]) begin
                n_bad++;
                $display("FAIL b2b_%0d: in=%b sel=%0d got %b want %b",
                         k, vi[k], vs[k], out2, ve[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        step2(4'b1101, 2'd3);
        n_cmp++;
        if (out2 !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: got %b want 1", out2);
        end
        RST = 1'b0;
        step2(4'b1101, 2'd3);
        n_cmp++;
        if (out2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_asserted: got %b want 0", out2);
        end
        RST = 1'b1;
        step2(4'b1101, 2'd3);
        n_cmp++;
        if (out2 !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_release: got %b want 1", out2);
        end
    endtask

    // Every code of the 8-input DUT: a lone 1 at the selected position must
    // come through, and a lone 0 at that position must also come through.
    task automatic test_exhaustive_w3;
        logic [7:0] one;
        for (int s = 0; s < 8; s++) begin
            one  = 8'd1 << s;
            in3  = one;
            sel3 = s[2:0];
            @(negedge CLK);
            n_cmp++;
            if (out3 !== 1'b1) begin
                n_bad++;
                $display("FAIL w3_onehot_sel%0d: got %b want 1", s, out3);
            end
            in3 = ~one;
            @(negedge CLK);
            n_cmp++;
            if (out3 !== 1'b0) begin
                n_bad++;
                $display("FAIL w3_onecold_sel%0d: got %b want 0", s, out3);
            end
        end
    endtask

    initial begin
        RST  = 1'b1;
        in2  = '0;
        sel2 = '0;
        in3  = '0;
        sel3 = '0;
        @(negedge CLK);
        test_reset();
        test_sel0();
        test_sel1();
        test_sel23();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive_w3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
